cla_pg_stage: RTL and testbench
===============================

# cla_pg_stage

Registered propagate/generate stage that sits directly upstream of the 4-group carry lookahead unit in the 16-bit CLA datapath. It accepts operand pairs over a valid/ready handshake and computes bit-level generate/propagate and 4-bit group G/P. It buffers up to two results and presents group G/P plus the carry-in (C0) to the lookahead unit. Bit-level P is passed through for the downstream sum stage.

## Interface
- WIDTH, 16, operand width; must be a multiple of GROUP
- GROUP, 4, bits per lookahead group; NGROUPS = WIDTH/GROUP = 4
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept; equals !rst && count<2
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream consumes head
- grp_g  output  NGROUPS  group generate, feeds lookahead G
- grp_p  output  NGROUPS  group propagate, feeds lookahead P
- c0  output  1  registered cin, feeds lookahead C0
- bit_p  output  WIDTH  bit propagate a^b, for sum stage
- bit_g  output  WIDTH  bit generate a&b

## Operation
- Bit level: g[i] = a[i]&b[i], p[i] = a[i]^b[i]. XOR is the propagate definition, so sum = p ^ carry downstream.
- Group j covers bits 4j+3..4j:
  - G = g3 | p3g2 | p3p2g1 | p3p2p1g0
  - P = p3&p2&p1&p0
- Results are computed combinationally from a/b and written into a 2-entry in-order buffer on push. Each entry holds {bit_g, bit_p, grp_g, grp_p, c0}.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- State machine (count):
  - EMPTY: push → ONE.
  - ONE: push&!pop → FULL; pop&!push → EMPTY; push&pop → ONE, with the new entry becoming head.
  - FULL: pop → ONE. A push is impossible because in_ready=0.
- out_valid = (state != EMPTY). The head entry drives all outputs.
- With out_valid=0, the data outputs hold the last head value. After reset they are zero.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- Reset values: state EMPTY, out_valid=0, in_ready=0 while rst=1, grp_g=0, grp_p=0, c0=0, bit_p=0, bit_g=0, both buffer entries cleared.
- Reset asserted mid-operation discards all buffered entries on that edge. in_ready rises in the first cycle after rst deasserts.

## Timing
- Latency is 1 cycle: a push at edge N gives out_valid=1 with that data after edge N when the buffer was EMPTY, or when ONE with a simultaneous pop.
- Throughput is 1 per cycle with out_ready held high.
- in_ready depends only on registered state, with no combinational path from out_ready. The FULL state absorbs one cycle of downstream stall.
- Outputs are register-driven. The lookahead unit's 4-unit combinational delay follows directly.
- A simultaneous push and pop in FULL cannot occur. In ONE it is a legal, lossless exchange.

## Structure
- Shared package cla_pkg holds:
  - WIDTH, GROUP, NGROUPS constants
  - pg_entry_t typedef {bit_g, bit_p, grp_g, grp_p, c0}
  - the state encoding EMPTY/ONE/FULL
- One sub-module, group_pg: combinational 4-bit g/p → group G/P. It is instantiated NGROUPS times.
- The buffer uses two pg_entry_t registers plus a head pointer or shift. Either is acceptable if ordering is preserved.

## Test plan
- a=16'hFFFF, b=16'h0001, cin=0, out_ready=1 → next cycle bit_g=16'h0001, bit_p=16'hFFFE, grp_g=4'b0001, grp_p=4'b1110, c0=0.
- a=16'h1234, b=16'h0000, cin=1 → bit_g=0, bit_p=16'h1234, grp_g=0, grp_p=0, c0=1.
- out_ready=0, three pushes attempted back-to-back → first two accepted, in_ready=0 on the third, out_valid stays 1. Then out_ready=1 → entries emerge in order over 2 cycles, and in_ready returns to 1 after the first pop.
- Streaming 8 vectors with out_ready=1 and in_valid=1 → one result per cycle, 1-cycle latency, order preserved, state oscillates only EMPTY/ONE.
- rst pulsed while FULL → next cycle out_valid=0 with all outputs zero; in_ready=1 once rst=0; the first subsequent push appears alone.
- Random a/b/cin with random out_ready → scoreboard checks that the grp_g/grp_p/c0 produced for each accepted operand pair, passed through the lookahead equations, gives (a+b+cin)[16:4] group carries.

Source files
------------

// File: rtl/cla_pg_stage_pkg.sv
// Shared constants, buffer entry type and buffer-state encoding for the
// propagate/generate stage that feeds the 4-group carry lookahead unit.
package cla_pkg;

   localparam int WIDTH   = 16;
   localparam int GROUP   = 4;
   localparam int NGROUPS = WIDTH / GROUP;

   typedef struct packed {
      logic [WIDTH-1:0]   bit_g;
      logic [WIDTH-1:0]   bit_p;
      logic [NGROUPS-1:0] grp_g;
      logic [NGROUPS-1:0] grp_p;
      logic               c0;
   } pg_entry_t;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/cla_pg_stage_if.sv
// Bundle of the operand-in and result-out handshakes of cla_pg_stage.
//   slave  : stage side (takes operands, drives results)
//   master : environment side (drives operands, takes results)
interface cla_pg_if;
   import cla_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic                cin;
   logic                out_valid;
   logic                out_ready;
   logic [NGROUPS-1:0]  grp_g;
   logic [NGROUPS-1:0]  grp_p;
   logic                c0;
   logic [WIDTH-1:0]    bit_p;
   logic [WIDTH-1:0]    bit_g;

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, grp_g, grp_p, c0, bit_p, bit_g
   );

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, grp_g, grp_p, c0, bit_p, bit_g
   );

endinterface

// File: rtl/cla_pg_stage_group_pg.sv
// group_pg: combinational group generate/propagate for one 4-bit group.
//   g, p : bit-level generate/propagate of the group (bit 3 = MSB)
//   gg   : group generate  g3 | p3g2 | p3p2g1 | p3p2p1g0
//   gp   : group propagate p3&p2&p1&p0
module group_pg (
   input  logic [3:0] g,
   input  logic [3:0] p,
   output logic       gg,
   output logic       gp
);

   assign gg = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
   assign gp = &p;

endmodule

// File: rtl/cla_pg_stage.sv
// cla_pg_stage: registered propagate/generate stage with a 2-entry in-order
// buffer, feeding group G/P and C0 to the lookahead unit and bit P/G to the
// sum stage.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : cla_pg_if.slave (a/b/cin in with valid/ready, results out with
//          valid/ready; all result outputs come straight from the head register)
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry buffered, out_valid=0
// ST_ONE   | head entry valid, tail free
// ST_FULL  | head and tail valid, in_ready=0
module cla_pg_stage
   import cla_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   cla_pg_if.slave  bus
);

   logic [WIDTH-1:0]   g_w;
   logic [WIDTH-1:0]   p_w;
   logic [NGROUPS-1:0] gg_w;
   logic [NGROUPS-1:0] gp_w;

   assign g_w = bus.a & bus.b;
   assign p_w = bus.a ^ bus.b;

   for (genvar j = 0; j < NGROUPS; j++) begin : g_grp
      group_pg u_group_pg (
         .g  (g_w[j*GROUP +: GROUP]),
         .p  (p_w[j*GROUP +: GROUP]),
         .gg (gg_w[j]),
         .gp (gp_w[j])
      );
   end

   pg_entry_t  new_ent;
   pg_entry_t  head_q;
   pg_entry_t  tail_q;
   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       push;
   logic       pop;

   assign new_ent = '{bit_g: g_w, bit_p: p_w, grp_g: gg_w, grp_p: gp_w, c0: bus.cin};

   // in_ready looks only at registered state and rst, never at out_ready
   assign bus.in_ready  = !rst && (state_q != ST_FULL);
   assign bus.out_valid = (state_q != ST_EMPTY);
   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (push) state_d = ST_ONE;
         ST_ONE: begin
            if (push && !pop)      state_d = ST_FULL;
            else if (pop && !push) state_d = ST_EMPTY;
         end
         ST_FULL:  if (pop) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // Shift organisation: head_q is always the oldest entry. When the buffer
   // drains, head_q keeps its last value so the outputs hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         if (pop && (state_q == ST_FULL))
            head_q <= tail_q;
         else if (push && ((state_q == ST_EMPTY) || pop))
            head_q <= new_ent;
         if (push && !pop && (state_q == ST_ONE))
            tail_q <= new_ent;
      end
   end

   assign bus.bit_g = head_q.bit_g;
   assign bus.bit_p = head_q.bit_p;
   assign bus.grp_g = head_q.grp_g;
   assign bus.grp_p = head_q.grp_p;
   assign bus.c0    = head_q.c0;

endmodule

// File: tb/tb_cla_pg_stage.sv
module tb_cla_pg_stage;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] eg;
      logic [15:0] ep;
      logic [3:0]  egg;
      logic [3:0]  egp;
   } vec_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
   } op_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   vec_t vec[8];
   op_t  sbq[$];
   op_t  op;

   cla_pg_if bus ();

   cla_pg_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input int i);
      bus.a   = vec[i].a;
      bus.b   = vec[i].b;
      bus.cin = vec[i].cin;
   endtask

   task automatic chk_head(input string tag, input int i);
      chk({tag, "_bit_g"}, {16'h0, bus.bit_g}, {16'h0, vec[i].eg});
      chk({tag, "_bit_p"}, {16'h0, bus.bit_p}, {16'h0, vec[i].ep});
      chk({tag, "_grp_g"}, {28'h0, bus.grp_g}, {28'h0, vec[i].egg});
      chk({tag, "_grp_p"}, {28'h0, bus.grp_p}, {28'h0, vec[i].egp});
      chk({tag, "_c0"}, {31'h0, bus.c0}, {31'h0, vec[i].cin});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] la_carries(logic [3:0] gg, logic [3:0] gp, logic c0);
      logic       c;
      logic [3:0] r;
      c = c0;
      for (int j = 0; j < 4; j++) begin
         c    = gg[j] | (gp[j] & c);
         r[j] = c;
      end
      return r;
   endfunction

   function automatic logic [3:0] true_carries(logic [15:0] a, logic [15:0] b, logic cin);
      logic [16:0] s;
      logic [3:0]  r;
      s = {1'b0, a} + {1'b0, b} + {16'h0, cin};
      for (int j = 0; j < 3; j++)
         r[j] = s[4*(j+1)] ^ a[4*(j+1)] ^ b[4*(j+1)];
      r[3] = s[16];
      return r;
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      //         a         b         cin   bit_g     bit_p     grp_g    grp_p
      vec[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0001, 16'hFFFE, 4'b0001, 4'b1110};
      vec[1] = '{16'h1234, 16'h0000, 1'b1, 16'h0000, 16'h1234, 4'b0000, 4'b0000};
      vec[2] = '{16'h00FF, 16'h00FF, 1'b0, 16'h00FF, 16'h0000, 4'b0011, 4'b0000};
      vec[3] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 16'hFFFF, 4'b0000, 4'b1111};
      vec[4] = '{16'h0F0F, 16'h0101, 1'b0, 16'h0101, 16'h0E0E, 4'b0101, 4'b0000};
      vec[5] = '{16'h8421, 16'h8421, 1'b1, 16'h8421, 16'h0000, 4'b1000, 4'b0000};
      vec[6] = '{16'h7000, 16'h1000, 1'b1, 16'h1000, 16'h6000, 4'b0000, 4'b0000};
      vec[7] = '{16'hF000, 16'h1000, 1'b0, 16'h1000, 16'hE000, 4'b1000, 4'b0000};

      // reset state
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = 16'h0;
      bus.b = 16'h0;
      bus.cin = 1'b0;
      repeat (3) tick();
      chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
      chk("rst_outputs", {bus.bit_g, bus.bit_p}, 32'h0);
      chk("rst_grp", {23'h0, bus.grp_g, bus.grp_p, bus.c0}, 32'h0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

      // streaming: one vector per cycle, out_ready held high
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(i);
         tick();
         chk($sformatf("stream%0d_out_valid", i), {31'h0, bus.out_valid}, 32'h1);
         chk($sformatf("stream%0d_in_ready", i), {31'h0, bus.in_ready}, 32'h1);
         chk_head($sformatf("stream%0d", i), i);
      end
      bus.in_valid = 1'b0;
      tick();
      chk("drain_out_valid", {31'h0, bus.out_valid}, 32'h0);
      chk_head("drain_hold", 7);

      // stall: three back-to-back pushes with out_ready low
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      drive(0);
      tick();
      drive(1);
      tick();
      chk("stall_in_ready", {31'h0, bus.in_ready}, 32'h0);
      chk("stall_out_valid", {31'h0, bus.out_valid}, 32'h1);
      drive(2);
      tick();
      chk("stall3_in_ready", {31'h0, bus.in_ready}, 32'h0);
      chk_head("stall_head", 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("pop1_in_ready", {31'h0, bus.in_ready}, 32'h1);
      chk("pop1_out_valid", {31'h0, bus.out_valid}, 32'h1);
      chk_head("pop1_head", 1);
      tick();
      chk("pop2_out_valid", {31'h0, bus.out_valid}, 32'h0);

      // reset while FULL
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      drive(3);
      tick();
      drive(4);
      tick();
      bus.in_valid = 1'b0;
      chk("prefill_in_ready", {31'h0, bus.in_ready}, 32'h0);
      rst = 1'b1;
      tick();
      chk("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("midrst_in_ready", {31'h0, bus.in_ready}, 32'h0);
      chk("midrst_outputs", {bus.bit_g, bus.bit_p}, 32'h0);
      chk("midrst_grp", {23'h0, bus.grp_g, bus.grp_p, bus.c0}, 32'h0);
      rst = 1'b0;
      #1;
      chk("midrst_release_in_ready", {31'h0, bus.in_ready}, 32'h1);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      drive(5);
      tick();
      bus.in_valid = 1'b0;
      chk("after_rst_out_valid", {31'h0, bus.out_valid}, 32'h1);
      chk_head("after_rst", 5);
      tick();
      chk("after_rst_alone", {31'h0, bus.out_valid}, 32'h0);

      // random traffic against a scoreboard and the lookahead equations
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.a         = 16'($urandom);
         bus.b         = 16'($urandom);
         bus.cin       = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         chk("rnd_out_valid", {31'h0, bus.out_valid}, {31'h0, sbq.size() != 0});
         chk("rnd_in_ready", {31'h0, bus.in_ready}, {31'h0, sbq.size() < 2});
         if (bus.out_valid && bus.out_ready && sbq.size() != 0) begin
            op = sbq.pop_front();
            chk("rnd_bit_gp", {bus.bit_g, bus.bit_p}, {op.a & op.b, op.a ^ op.b});
            chk("rnd_c0", {31'h0, bus.c0}, {31'h0, op.cin});
            chk("rnd_carries", {28'h0, la_carries(bus.grp_g, bus.grp_p, bus.c0)},
                {28'h0, true_carries(op.a, op.b, op.cin)});
         end
         if (bus.in_valid && bus.in_ready)
            sbq.push_back('{bus.a, bus.b, bus.cin});
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
